// File: rtl/manager_chan_pkg.sv
// Shared defaults and helpers for the manager channel bank.
// Lane slicing and modulo-depth pointer stepping live here.
package manager_chan_pkg;

    localparam int NUM_CH_DEF  = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int BUF_D_DEF   = 7;
    localparam int OREG_EN_DEF = 0;

    // Low bit of lane `lane` in a packed vector of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // Pointer step with explicit wrap; depth need not be a power of two.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/manager_lane_fifo.sv
// One buffered AXI-stream lane: storage, pointers, occupancy,
// optional output register, synchronous flush and status flags.
module manager_lane_fifo
    import manager_chan_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BUF_D     = 7,
    parameter int OREG_EN   = 0,
    parameter int AF_THRESH = 5,
    parameter int CNT_W     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              s_vld,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_rdy,
    output logic              m_vld,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_rdy,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_afull,
    output logic              o_empty
);

    localparam int CAP   = BUF_D + OREG_EN;
    localparam int PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    logic [DATA_W-1:0] mem [BUF_D];
    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t cnt;
    cnt_t cnt_nxt;
    logic rdy_en;
    logic afull_q;
    logic empty_q;
    logic push;
    logic pop;
    logic rd_adv;
    logic full;

    assign full    = (cnt == cnt_t'(CAP));
    assign s_rdy   = rdy_en & ~full & ~i_flush;
    assign push    = s_vld & s_rdy;
    assign pop     = m_vld & m_rdy;
    assign o_count = cnt;
    assign o_afull = afull_q;
    assign o_empty = empty_q;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // Pointer update; flush rewinds both.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_t'(ptr_inc(int'(wr_ptr), BUF_D));
            if (rd_adv) rd_ptr <= ptr_t'(ptr_inc(int'(rd_ptr), BUF_D));
        end
    end

    // Next occupancy: flush wins, then +1 push-only, -1 pop-only.
    always_comb begin
        cnt_nxt = cnt;
        if (i_flush)           cnt_nxt = '0;
        else if (push && !pop) cnt_nxt = cnt + cnt_t'(1);
        else if (pop && !push) cnt_nxt = cnt - cnt_t'(1);
    end

    // Occupancy and flags registered from the next count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt     <= '0;
            afull_q <= 1'b0;
            empty_q <= 1'b1;
            rdy_en  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            afull_q <= (cnt_nxt >= cnt_t'(AF_THRESH));
            empty_q <= (cnt_nxt == '0);
            rdy_en  <= 1'b1;
        end
    end

    generate
        if (OREG_EN != 0) begin : g_oreg
            logic              oreg_vld;
            logic [DATA_W-1:0] oreg_data;
            cnt_t              sc;
            logic              load;

            assign sc     = cnt - cnt_t'(oreg_vld);
            assign load   = (sc != '0) & (~oreg_vld | m_rdy) & ~i_flush;
            assign rd_adv = load;
            assign m_vld  = oreg_vld;
            assign m_data = oreg_data;

            // Output register refills in the same cycle it is popped.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    oreg_vld  <= 1'b0;
                    oreg_data <= '0;
                end else if (i_flush) begin
                    oreg_vld  <= 1'b0;
                    oreg_data <= '0;
                end else if (load) begin
                    oreg_vld  <= 1'b1;
                    oreg_data <= mem[rd_ptr];
                end else if (m_rdy) begin
                    oreg_vld  <= 1'b0;
                end
            end
        end else begin : g_fwft
            assign rd_adv = pop;
            assign m_vld  = (cnt != '0);
            assign m_data = m_vld ? mem[rd_ptr] : '0;
        end
    endgenerate

    a_no_overflow : assert property (
        @(posedge i_clk) disable iff (!i_rst) push |-> (cnt != cnt_t'(CAP))
    );
    a_no_underflow : assert property (
        @(posedge i_clk) disable iff (!i_rst) pop |-> (cnt != '0)
    );

endmodule

// File: rtl/manager_channel_bank.sv
// NUM_CH independent buffered AXI-stream lanes on one clock.
// Top level only slices packed vectors onto per-lane FIFOs.
module manager_channel_bank
    import manager_chan_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_D     = BUF_D_DEF,
    parameter int OREG_EN   = OREG_EN_DEF,
    parameter int AF_THRESH = BUF_D - 2,
    parameter int CNT_W     = $clog2(BUF_D + 2)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_flush,
    input  logic [NUM_CH-1:0]        s_vld,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    output logic [NUM_CH-1:0]        s_rdy,
    output logic [NUM_CH-1:0]        m_vld,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    input  logic [NUM_CH-1:0]        m_rdy,
    output logic [NUM_CH*CNT_W-1:0]  o_count,
    output logic [NUM_CH-1:0]        o_afull,
    output logic [NUM_CH-1:0]        o_empty
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        manager_lane_fifo #(
            .DATA_W    (DATA_W),
            .BUF_D     (BUF_D),
            .OREG_EN   (OREG_EN),
            .AF_THRESH (AF_THRESH),
            .CNT_W     (CNT_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_flush (i_flush[g]),
            .s_vld   (s_vld[g]),
            .s_data  (s_data[lane_lo(g, DATA_W) +: DATA_W]),
            .s_rdy   (s_rdy[g]),
            .m_vld   (m_vld[g]),
            .m_data  (m_data[lane_lo(g, DATA_W) +: DATA_W]),
            .m_rdy   (m_rdy[g]),
            .o_count (o_count[lane_lo(g, CNT_W) +: CNT_W]),
            .o_afull (o_afull[g]),
            .o_empty (o_empty[g])
        );
    end

endmodule

// File: tb/tb_manager_channel_bank.sv
// Scoreboard bench for manager_channel_bank, both output modes.
// Directed vectors; a negedge monitor checks every transfer.
module tb_manager_channel_bank;

    logic        clk;
    logic        rst_n;
    logic [3:0]  flush  [2];
    logic [3:0]  s_vld  [2];
    logic [31:0] s_data [2];
    logic [3:0]  s_rdy  [2];
    logic [3:0]  m_vld  [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_rdy  [2];
    logic [15:0] o_count[2];
    logic [3:0]  o_afull[2];
    logic [3:0]  o_empty[2];

    int nvec;
    int nerr;

    logic [7:0] sbq [8][$];
    logic       hold_v [8];
    logic [7:0] hold_d [8];

    manager_channel_bank #(.OREG_EN(0)) u_bank0 (
        .i_clk(clk), .i_rst(rst_n), .i_flush(flush[0]),
        .s_vld(s_vld[0]), .s_data(s_data[0]), .s_rdy(s_rdy[0]),
        .m_vld(m_vld[0]), .m_data(m_data[0]), .m_rdy(m_rdy[0]),
        .o_count(o_count[0]), .o_afull(o_afull[0]), .o_empty(o_empty[0])
    );

    manager_channel_bank #(.OREG_EN(1)) u_bank1 (
        .i_clk(clk), .i_rst(rst_n), .i_flush(flush[1]),
        .s_vld(s_vld[1]), .s_data(s_data[1]), .s_rdy(s_rdy[1]),
        .m_vld(m_vld[1]), .m_data(m_data[1]), .m_rdy(m_rdy[1]),
        .o_count(o_count[1]), .o_afull(o_afull[1]), .o_empty(o_empty[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: handshakes are stable at negedge, equal to next posedge.
    always @(negedge clk) begin
        int qi;
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 4; l++) begin
                qi = k * 4 + l;
                if (!rst_n) begin
                    sbq[qi].delete();
                    hold_v[qi] = 1'b0;
                end else begin
                    chk("count", int'(o_count[k][l*4 +: 4]), sbq[qi].size());
                    chk("empty", int'(o_empty[k][l]), int'(sbq[qi].size() == 0));
                    chk("afull", int'(o_afull[k][l]), int'(sbq[qi].size() >= 5));
                    if (hold_v[qi]) begin
                        chk("hold_vld", int'(m_vld[k][l]), 1);
                        chk("hold_data", int'(m_data[k][l*8 +: 8]), int'(hold_d[qi]));
                    end
                    if (m_vld[k][l] && m_rdy[k][l]) begin
                        if (sbq[qi].size() == 0)
                            chk("pop_underrun", sbq[qi].size(), 1);
                        else
                            chk("pop_data", int'(m_data[k][l*8 +: 8]),
                                int'(sbq[qi].pop_front()));
                    end
                    hold_v[qi] = m_vld[k][l] && !m_rdy[k][l] && !flush[k][l];
                    hold_d[qi] = m_data[k][l*8 +: 8];
                    if (s_vld[k][l] && s_rdy[k][l])
                        sbq[qi].push_back(s_data[k][l*8 +: 8]);
                    if (flush[k][l])
                        sbq[qi].delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int pend(input int k);
        int s;
        s = 0;
        for (int l = 0; l < 4; l++) s += sbq[k*4 + l].size();
        return s;
    endfunction

    task automatic drain(input int k);
        s_vld[k] = '0;
        m_rdy[k] = 4'hF;
        for (int i = 0; i < 40; i++) begin
            if (pend(k) == 0) break;
            step();
        end
        chk("drain_left", pend(k), 0);
        m_rdy[k] = '0;
        step();
    endtask

    task automatic run(input int k);
        int cap;
        int d;
        logic acc;
        logic [7:0] dl [4];
        cap = 7 + k;

        rst_n = 1'b0;
        s_vld[k] = '0; m_rdy[k] = '0; flush[k] = '0; s_data[k] = '0;
        step();
        chk("rst_srdy", int'(s_rdy[k]), 0);
        chk("rst_mvld", int'(m_vld[k]), 0);
        chk("rst_mdata", int'(m_data[k]), 0);
        chk("rst_count", int'(o_count[k]), 0);
        chk("rst_afull", int'(o_afull[k]), 0);
        chk("rst_empty", int'(o_empty[k]), 4'hF);
        rst_n = 1'b1;

        // First word latency on lane 2
        step();
        chk("rel_srdy", int'(s_rdy[k]), 4'hF);
        step();
        s_vld[k][2] = 1'b1;
        s_data[k][23:16] = 8'h11;
        step();
        s_vld[k] = '0;
        #1;
        chk("lat_e3_mvld", int'(m_vld[k][2]), int'(k == 0));
        step();
        #1;
        chk("lat_e4_mvld", int'(m_vld[k][2]), 1);
        chk("lat_mdata", int'(m_data[k][23:16]), 8'h11);
        chk("lat_others", int'(m_vld[k] & 4'hB), 0);
        chk("lat_empty", int'(o_empty[k]), 4'hB);
        drain(k);

        // Fill lane 0 to capacity
        d = 1;
        for (int i = 0; i < cap + 4; i++) begin
            s_vld[k][0] = 1'b1;
            s_data[k][7:0] = 8'(d);
            #1;
            acc = s_rdy[k][0];
            step();
            if (acc) d++;
        end
        chk("fill_words", d - 1, cap);
        chk("fill_count", int'(o_count[k][3:0]), cap);
        chk("fill_srdy", int'(s_rdy[k][0]), 0);
        chk("fill_afull", int'(o_afull[k][0]), 1);
        m_rdy[k][0] = 1'b1;
        #1;
        chk("full_pop_srdy", int'(s_rdy[k][0]), 0);
        step();
        s_vld[k] = '0;
        m_rdy[k] = '0;
        #1;
        chk("after_pop_srdy", int'(s_rdy[k][0]), 1);
        chk("after_pop_count", int'(o_count[k][3:0]), cap - 1);
        chk("after_pop_head", int'(m_data[k][7:0]), 8'h02);
        drain(k);

        // Streaming on lane 1 with random back-pressure
        d = 8'h40;
        for (int i = 0; i < 20; i++) begin
            s_vld[k][1] = 1'b1;
            s_data[k][15:8] = 8'(d);
            m_rdy[k][1] = 1'($urandom_range(0, 1));
            #1;
            acc = s_rdy[k][1];
            step();
            if (acc) d++;
        end
        drain(k);

        // Flush lane 3 while lane 0 holds a word
        for (int i = 0; i < 4; i++) begin
            s_vld[k] = (i == 0) ? 4'b1001 : 4'b1000;
            s_data[k][31:24] = 8'(8'h30 + i);
            s_data[k][7:0] = 8'hC0;
            step();
        end
        s_vld[k] = '0;
        step();
        chk("pre_flush_count", int'(o_count[k][15:12]), 4);
        flush[k][3] = 1'b1;
        s_vld[k][3] = 1'b1;
        m_rdy[k][3] = 1'b1;
        #1;
        chk("flush_srdy", int'(s_rdy[k][3]), 0);
        step();
        flush[k] = '0;
        s_vld[k] = '0;
        m_rdy[k] = '0;
        #1;
        chk("flush_count", int'(o_count[k][15:12]), 0);
        chk("flush_mvld", int'(m_vld[k][3]), 0);
        chk("flush_empty", int'(o_empty[k][3]), 1);
        chk("flush_l0_count", int'(o_count[k][3:0]), 1);
        chk("flush_l0_data", int'(m_data[k][7:0]), 8'hC0);
        drain(k);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            s_vld[k] = 4'hF;
            m_rdy[k] = (i < 2) ? 4'h0 : 4'hF;
            s_data[k] = {4{8'(8'h70 + i)}};
            step();
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mvld", int'(m_vld[k]), 0);
        chk("arst_mdata", int'(m_data[k]), 0);
        chk("arst_count", int'(o_count[k]), 0);
        chk("arst_empty", int'(o_empty[k]), 4'hF);
        chk("arst_afull", int'(o_afull[k]), 0);
        chk("arst_srdy", int'(s_rdy[k]), 0);
        s_vld[k] = '0;
        m_rdy[k] = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        s_vld[k][0] = 1'b1;
        s_data[k][7:0] = 8'hA5;
        step();
        s_vld[k] = '0;
        for (int i = 0; i < 5; i++) begin
            if (m_vld[k][0]) break;
            step();
        end
        chk("arst_first_vld", int'(m_vld[k][0]), 1);
        chk("arst_first_data", int'(m_data[k][7:0]), 8'hA5);
        drain(k);

        // All lanes concurrently with distinct patterns
        dl[0] = 8'h00; dl[1] = 8'hFF; dl[2] = 8'h50; dl[3] = 8'h80;
        for (int i = 0; i < 16; i++) begin
            s_vld[k] = 4'hF;
            for (int l = 0; l < 4; l++) s_data[k][l*8 +: 8] = dl[l];
            m_rdy[k] = 4'($urandom_range(0, 15));
            #1;
            for (int l = 0; l < 4; l++) begin
                if (s_rdy[k][l]) begin
                    case (l)
                        0: dl[l] = dl[l] + 8'h01;
                        1: dl[l] = dl[l] - 8'h01;
                        2: dl[l] = dl[l] + 8'h03;
                        default: dl[l] = dl[l] ^ 8'h05 + 8'h01;
                    endcase
                end
            end
            step();
        end
        drain(k);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            flush[k] = '0; s_vld[k] = '0; s_data[k] = '0; m_rdy[k] = '0;
        end
        for (int q = 0; q < 8; q++) begin
            hold_v[q] = 1'b0;
            hold_d[q] = '0;
        end
        run(0);
        run(1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
